// File: rtl/prng_lfsr_stream_pkg.sv
// Shared constants, FSM state type and the single Galois LFSR step used by the PRNG stream.
package prng_pkg;

   localparam logic [15:0] PRNG_POLY16 = 16'h00AF;
   localparam logic [15:0] PRNG_SEED16 = 16'hACE1;
   localparam int unsigned PRNG_MAX_W  = 64;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } prng_state_e;

   // Operates on a zero-extended MAX_W-bit container; width selects the live LFSR bits.
   function automatic logic [PRNG_MAX_W-1:0] lfsr_step(
      input logic [PRNG_MAX_W-1:0] state,
      input logic [PRNG_MAX_W-1:0] poly,
      input int unsigned           width
   );
      logic [PRNG_MAX_W-1:0] mask;
      logic [PRNG_MAX_W-1:0] next;
      logic                  msb;
      mask = {PRNG_MAX_W{1'b1}} >> (PRNG_MAX_W - width);
      msb  = |(state & ({{(PRNG_MAX_W-1){1'b0}}, 1'b1} << (width - 1)));
      next = (state << 1) & mask;
      if (msb) begin
         next = next ^ (poly & mask);
      end
      return next;
   endfunction

endpackage

// File: rtl/prng_lfsr_stream_galois_adv.sv
// Combinational multi-step Galois LFSR advance: applies STEPS single steps to the state.
module prng_galois_adv
   import prng_pkg::*;
#(
   parameter int unsigned      WIDTH = 16,
   parameter logic [WIDTH-1:0] POLY  = PRNG_POLY16,
   parameter int unsigned      STEPS = 1
) (
   input  logic [WIDTH-1:0] state,
   output logic [WIDTH-1:0] next
);

   logic [PRNG_MAX_W-1:0] work;

   always_comb begin
      work              = '0;
      work[WIDTH-1:0]   = state;
      for (int unsigned i = 0; i < STEPS; i++) begin
         work = lfsr_step(work, PRNG_MAX_W'(POLY), WIDTH);
      end
      next = work[WIDTH-1:0];
   end

endmodule

// File: rtl/prng_lfsr_stream.sv
// Galois-LFSR random word stream with seed load, bounded/free-running bursts and valid/ready output.
module prng_lfsr_stream
   import prng_pkg::*;
#(
   parameter int unsigned      WIDTH        = 16,
   parameter logic [WIDTH-1:0] POLY         = PRNG_POLY16,
   parameter int unsigned      STEPS        = 1,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = PRNG_SEED16,
   parameter int unsigned      CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
   input  logic             start,
   input  logic [CNT_W-1:0] burst_len,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             seed_zero
);

   prng_state_e      fsm_q;
   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] state_adv;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] len_q;
   logic             seed_zero_q;
   logic             acc;

   prng_galois_adv #(
      .WIDTH (WIDTH),
      .POLY  (POLY),
      .STEPS (STEPS)
   ) u_adv (
      .state (state_q),
      .next  (state_adv)
   );

   assign out_valid = (fsm_q == RUN);
   assign busy      = out_valid;
   assign out_data  = state_q;
   assign out_last  = out_valid && (len_q != '0) && (count_q == len_q - CNT_W'(1));
   assign seed_zero = seed_zero_q;
   assign acc       = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q       <= IDLE;
         state_q     <= DEFAULT_SEED;
         count_q     <= '0;
         len_q       <= '0;
         seed_zero_q <= 1'b0;
      end else if (seed_load) begin
         // Seed load overrides start and accept; an all-zero seed would lock the LFSR.
         state_q <= (seed == '0) ? DEFAULT_SEED : seed;
         if (seed == '0) begin
            seed_zero_q <= 1'b1;
         end
         fsm_q   <= IDLE;
         count_q <= '0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (start) begin
                  len_q   <= burst_len;
                  count_q <= '0;
                  fsm_q   <= RUN;
               end
            end
            RUN: begin
               if (acc) begin
                  state_q <= state_adv;
                  count_q <= count_q + CNT_W'(1);
                  if (out_last) begin
                     fsm_q <= IDLE;
                  end
               end
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

   a_poly_lsb: assert property (@(posedge clk) POLY[0] == 1'b1);

endmodule

// File: tb/tb_prng_lfsr_stream.sv
// Directed bench for prng_lfsr_stream: STEPS=1 and STEPS=2 instances checked against a word-level model.
module tb_prng_lfsr_stream;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        seed_load = 1'b0;
   logic [15:0] seed = '0;
   logic        start = 1'b0;
   logic [15:0] burst_len = '0;
   logic        out_ready = 1'b1;

   logic        busy [2];
   logic        valid [2];
   logic [15:0] data [2];
   logic        last [2];
   logic        szero [2];

   int vectors = 0;
   int miscompares = 0;
   bit en = 1'b0;

   always #5 clk = ~clk;

   prng_lfsr_stream #(
      .WIDTH(16), .POLY(16'h00AF), .STEPS(1), .DEFAULT_SEED(16'hACE1), .CNT_W(16)
   ) u_a (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .start(start),
      .burst_len(burst_len), .busy(busy[0]), .out_valid(valid[0]), .out_ready(out_ready),
      .out_data(data[0]), .out_last(last[0]), .seed_zero(szero[0])
   );

   prng_lfsr_stream #(
      .WIDTH(16), .POLY(16'h00AF), .STEPS(2), .DEFAULT_SEED(16'hACE1), .CNT_W(16)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .start(start),
      .burst_len(burst_len), .busy(busy[1]), .out_valid(valid[1]), .out_ready(out_ready),
      .out_data(data[1]), .out_last(last[1]), .seed_zero(szero[1])
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Word-level model: the sequence is x(n+1) = 2*x(n) mod 2^16, folded with 0x00AF on overflow.
   logic [15:0] m_state [2];
   bit          m_active [2];
   int          m_len [2];
   int          m_idx [2];
   bit          m_sz [2];

   function automatic logic [15:0] step16(input logic [15:0] s);
      int v;
      v = int'(s) * 2;
      if (v >= 65536) return 16'(v - 65536) ^ 16'h00AF;
      return 16'(v);
   endfunction

   function automatic bit model_last(input int k);
      return m_active[k] && (m_len[k] != 0) && (m_idx[k] == m_len[k] - 1);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_state[k]  <= 16'hACE1;
            m_active[k] <= 1'b0;
            m_len[k]    <= 0;
            m_idx[k]    <= 0;
            m_sz[k]     <= 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (seed_load) begin
               m_state[k]  <= (seed == 16'h0) ? 16'hACE1 : seed;
               if (seed == 16'h0) m_sz[k] <= 1'b1;
               m_active[k] <= 1'b0;
               m_idx[k]    <= 0;
            end else if (!m_active[k]) begin
               if (start) begin
                  m_active[k] <= 1'b1;
                  m_len[k]    <= int'(burst_len);
                  m_idx[k]    <= 0;
               end
            end else if (out_ready) begin
               logic [15:0] s;
               s = m_state[k];
               for (int j = 0; j <= k; j++) s = step16(s);
               m_state[k] <= s;
               m_idx[k]   <= (m_idx[k] + 1) % 65536;
               if (model_last(k)) m_active[k] <= 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (en) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d.out_valid", k), 32'(valid[k]), 32'(m_active[k]));
            chk($sformatf("u%0d.busy", k),      32'(busy[k]),  32'(m_active[k]));
            chk($sformatf("u%0d.out_data", k),  32'(data[k]),  32'(m_state[k]));
            chk($sformatf("u%0d.out_last", k),  32'(last[k]),  32'(model_last(k)));
            chk($sformatf("u%0d.seed_zero", k), 32'(szero[k]), 32'(m_sz[k]));
         end
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1 en = 1'b1;
      cyc(2);
      chk("reset.data", 32'(data[0]), 32'h0000ACE1);
      chk("reset.valid", 32'(valid[0]), 32'h0);
      chk("reset.busy", 32'(busy[0]), 32'h0);
      chk("reset.seed_zero", 32'(szero[0]), 32'h0);
      rst_n = 1'b1;

      // bounded burst of 3 from seed 1
      seed_load = 1'b1; seed = 16'h0001;
      cyc();
      seed_load = 1'b0; start = 1'b1; burst_len = 16'd3;
      cyc();
      start = 1'b0;
      chk("b3.w0", 32'(data[0]), 32'h0001); chk("b3.l0", 32'(last[0]), 32'h0);
      chk("s2.w0", 32'(data[1]), 32'h0001);
      cyc();
      chk("b3.w1", 32'(data[0]), 32'h0002); chk("b3.l1", 32'(last[0]), 32'h0);
      chk("s2.w1", 32'(data[1]), 32'h0004);
      cyc();
      chk("b3.w2", 32'(data[0]), 32'h0004); chk("b3.l2", 32'(last[0]), 32'h1);
      chk("s2.w2", 32'(data[1]), 32'h0010); chk("s2.l2", 32'(last[1]), 32'h1);
      cyc();
      chk("b3.idle", 32'(valid[0]), 32'h0);

      // free-running from seed 1: taps appear after the MSB shifts out
      seed_load = 1'b1; seed = 16'h0001;
      cyc();
      seed_load = 1'b0; start = 1'b1; burst_len = 16'd0;
      cyc();
      start = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         cyc();
         if (i == 15) chk("free.w15", 32'(data[0]), 32'h8000);
         if (i == 16) chk("free.w16", 32'(data[0]), 32'h00AF);
      end
      chk("free.last", 32'(last[0]), 32'h0);
      seed_load = 1'b1; seed = 16'h0001;
      cyc();
      chk("free.abort", 32'(valid[0]), 32'h0);

      // backpressure in a 4-word burst
      seed_load = 1'b0; start = 1'b1; burst_len = 16'd4;
      cyc();
      start = 1'b0;
      chk("bp.w0", 32'(data[0]), 32'h0001);
      cyc();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("bp.hold", 32'(data[0]), 32'h0002);
         chk("bp.hold_valid", 32'(valid[0]), 32'h1);
         cyc();
      end
      out_ready = 1'b1;
      chk("bp.w1", 32'(data[0]), 32'h0002);
      cyc();
      chk("bp.w2", 32'(data[0]), 32'h0004); chk("bp.l2", 32'(last[0]), 32'h0);
      cyc();
      chk("bp.w3", 32'(data[0]), 32'h0008); chk("bp.l3", 32'(last[0]), 32'h1);
      cyc();
      chk("bp.idle", 32'(valid[0]), 32'h0);

      // zero seed mid-burst aborts and substitutes the default
      seed_load = 1'b1; seed = 16'h0001;
      cyc();
      seed_load = 1'b0; start = 1'b1; burst_len = 16'd5;
      cyc();
      start = 1'b0;
      cyc();
      seed_load = 1'b1; seed = 16'h0000;
      cyc();
      seed_load = 1'b0;
      chk("zs.valid", 32'(valid[0]), 32'h0);
      chk("zs.last", 32'(last[0]), 32'h0);
      chk("zs.data", 32'(data[0]), 32'h0000ACE1);
      chk("zs.flag", 32'(szero[0]), 32'h1);
      cyc(3);
      chk("zs.sticky", 32'(szero[0]), 32'h1);

      // asynchronous reset mid free-running burst
      start = 1'b1; burst_len = 16'd0;
      cyc();
      start = 1'b0;
      cyc(2);
      #2 rst_n = 1'b0;
      #1;
      chk("ar.data", 32'(data[0]), 32'h0000ACE1);
      chk("ar.valid", 32'(valid[0]), 32'h0);
      chk("ar.busy", 32'(busy[0]), 32'h0);
      chk("ar.last", 32'(last[0]), 32'h0);
      chk("ar.seed_zero", 32'(szero[0]), 32'h0);
      cyc();
      rst_n = 1'b1;
      cyc(2);
      en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
